ram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller placed directly upstream of the 16x32 single-port DFF RAM. It owns the RAM's CLK-domain control port (EN, WE, RE, A, Di) and consumes its registered Do.
- Converts a write-valid/ready stream and a read-request stream into RAM accesses.
- Tracks full/empty/occupancy and returns read data with a one-cycle-latency valid strobe.
- The RAM is instantiated beside it at the subsystem top.

---
 rtl/ram_pkg.sv | 8 +
 rtl/fifo_ptr.sv | 28 ++
 rtl/ram_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared sizing for the 16x32 single-port DFF RAM and the FIFO controller in front of it.
package ram_pkg;
  localparam int ADDR_LEN_DEF = 4;
  localparam int DATA_LEN_DEF = 32;
  localparam int DEPTH        = 2 ** ADDR_LEN_DEF;
  localparam int COUNT_W      = ADDR_LEN_DEF + 1;
  localparam int AFULL_DEF    = 12;
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address pointer: advances by one when inc_i is high, wraps naturally at 2**W.
module fifo_ptr
  import ram_pkg::*;
#(
  parameter int W = ADDR_LEN_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-port DFF RAM; reads win arbitration, read data
// returns one cycle after acceptance and is held stable between reads.
module ram_fifo_ctrl
  import ram_pkg::*;
#(
  parameter int ADDRESS_LENGTH = ADDR_LEN_DEF,
  parameter int DATA_LENGTH    = DATA_LEN_DEF,
  parameter int AFULL_LEVEL    = AFULL_DEF
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      WR_VALID,
  output logic                      WR_READY,
  input  logic [DATA_LENGTH-1:0]    WR_DATA,
  input  logic                      RD_REQ,
  output logic                      RD_VALID,
  output logic [DATA_LENGTH-1:0]    RD_DATA,
  output logic                      EMPTY,
  output logic                      FULL,
  output logic                      ALMOST_FULL,
  output logic [ADDRESS_LENGTH:0]   COUNT,
  output logic                      RAM_EN,
  output logic                      RAM_WE,
  output logic                      RAM_RE,
  output logic [ADDRESS_LENGTH-1:0] RAM_A,
  output logic [DATA_LENGTH-1:0]    RAM_DI,
  input  logic [DATA_LENGTH-1:0]    RAM_DO
);

  localparam logic [ADDRESS_LENGTH:0] DEPTH_C = (ADDRESS_LENGTH+1)'(2 ** ADDRESS_LENGTH);
  localparam logic [ADDRESS_LENGTH:0] AFULL_C = (ADDRESS_LENGTH+1)'(AFULL_LEVEL);

  logic                      rd_acc;
  logic                      wr_acc;
  logic [ADDRESS_LENGTH-1:0] wr_ptr;
  logic [ADDRESS_LENGTH-1:0] rd_ptr;
  logic [ADDRESS_LENGTH:0]   count_q;
  logic [ADDRESS_LENGTH:0]   count_d;
  logic                      rd_valid_q;
  logic [DATA_LENGTH-1:0]    hold_q;
  logic [DATA_LENGTH-1:0]    hold_d;

  // Flags come only from the registered count.
  assign EMPTY       = (count_q == '0);
  assign FULL        = (count_q == DEPTH_C);
  assign ALMOST_FULL = (count_q >= AFULL_C);
  assign COUNT       = count_q;

  // Accesses are suppressed while reset is asserted so the RAM sees no stray writes.
  assign rd_acc   = RSTn && RD_REQ && !EMPTY;
  assign WR_READY = RSTn && !FULL && !rd_acc;
  assign wr_acc   = WR_VALID && WR_READY;

  assign RAM_EN = rd_acc | wr_acc;
  assign RAM_RE = rd_acc;
  assign RAM_WE = wr_acc;
  assign RAM_A  = rd_acc ? rd_ptr : wr_ptr;
  assign RAM_DI = WR_DATA;

  fifo_ptr #(.W(ADDRESS_LENGTH)) u_wr_ptr (
    .clk_i   (CLK),
    .rst_n_i (RSTn),
    .inc_i   (wr_acc),
    .ptr_o   (wr_ptr)
  );

  fifo_ptr #(.W(ADDRESS_LENGTH)) u_rd_ptr (
    .clk_i   (CLK),
    .rst_n_i (RSTn),
    .inc_i   (rd_acc),
    .ptr_o   (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (wr_acc)      count_d = count_q + 1'b1;
    else if (rd_acc) count_d = count_q - 1'b1;
  end

  // RAM_DO is zero on idle cycles, so only pass it through on the return cycle.
  assign RD_VALID = rd_valid_q && RSTn;
  assign RD_DATA  = RD_VALID ? RAM_DO : hold_q;

  always_comb begin
    hold_d = hold_q;
    if (RD_VALID) hold_d = RAM_DO;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 16x32 RAM beside it and a queue-based reference model.
module tb_ram_fifo_ctrl;
  import ram_pkg::*;

  logic        clk = 1'b0;
  logic        RSTn;
  logic        WR_VALID;
  logic        WR_READY;
  logic [31:0] WR_DATA;
  logic        RD_REQ;
  logic        RD_VALID;
  logic [31:0] RD_DATA;
  logic        EMPTY;
  logic        FULL;
  logic        ALMOST_FULL;
  logic [4:0]  COUNT;
  logic        RAM_EN;
  logic        RAM_WE;
  logic        RAM_RE;
  logic [3:0]  RAM_A;
  logic [31:0] RAM_DI;
  logic [31:0] RAM_DO = '0;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .CLK         (clk),
    .RSTn        (RSTn),
    .WR_VALID    (WR_VALID),
    .WR_READY    (WR_READY),
    .WR_DATA     (WR_DATA),
    .RD_REQ      (RD_REQ),
    .RD_VALID    (RD_VALID),
    .RD_DATA     (RD_DATA),
    .EMPTY       (EMPTY),
    .FULL        (FULL),
    .ALMOST_FULL (ALMOST_FULL),
    .COUNT       (COUNT),
    .RAM_EN      (RAM_EN),
    .RAM_WE      (RAM_WE),
    .RAM_RE      (RAM_RE),
    .RAM_A       (RAM_A),
    .RAM_DI      (RAM_DI),
    .RAM_DO      (RAM_DO)
  );

  // Single-port DFF RAM: registered Do, zeroed on cycles without a read.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (RAM_EN) begin
      if (RAM_WE) mem[RAM_A] <= RAM_DI;
      RAM_DO <= RAM_RE ? mem[RAM_A] : 32'h0;
    end else begin
      RAM_DO <= 32'h0;
    end
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: the FIFO is a queue; addresses are write/read totals mod 16.
  logic [31:0] mq [$];
  logic [31:0] obs [$];
  bit          mon_en = 1'b0;
  bit          m_rv   = 1'b0;
  logic [31:0] m_word = '0;
  logic [31:0] m_hold = '0;
  int          m_wp   = 0;
  int          m_rp   = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      bit          ra;
      bit          wa;
      int          sz;
      logic [31:0] exp_rd;
      sz     = mq.size();
      ra     = RSTn && RD_REQ && (sz != 0);
      wa     = RSTn && WR_VALID && (sz != DEPTH) && !ra;
      exp_rd = (m_rv && RSTn) ? m_word : m_hold;

      n_total++;
      if (COUNT !== 5'(sz)) $display("FAIL mon_count got %0d want %0d t=%0t", COUNT, sz, $time);
      else n_pass++;
      n_total++;
      if (EMPTY !== (sz == 0)) $display("FAIL mon_empty got %b want %b t=%0t", EMPTY, (sz == 0), $time);
      else n_pass++;
      n_total++;
      if (FULL !== (sz == DEPTH)) $display("FAIL mon_full got %b want %b t=%0t", FULL, (sz == DEPTH), $time);
      else n_pass++;
      n_total++;
      if (ALMOST_FULL !== (sz >= AFULL_DEF)) $display("FAIL mon_afull got %b want %b t=%0t", ALMOST_FULL, (sz >= AFULL_DEF), $time);
      else n_pass++;
      n_total++;
      if (WR_READY !== (RSTn && sz != DEPTH && !ra)) $display("FAIL mon_wr_ready got %b want %b t=%0t", WR_READY, (RSTn && sz != DEPTH && !ra), $time);
      else n_pass++;
      n_total++;
      if ({RAM_EN, RAM_WE, RAM_RE} !== {ra | wa, wa, ra}) $display("FAIL mon_ram_ctl got %b want %b t=%0t", {RAM_EN, RAM_WE, RAM_RE}, {ra | wa, wa, ra}, $time);
      else n_pass++;
      if (ra || wa) begin
        n_total++;
        if (RAM_A !== 4'(ra ? m_rp : m_wp)) $display("FAIL mon_ram_a got %0d want %0d t=%0t", RAM_A, (ra ? m_rp : m_wp), $time);
        else n_pass++;
      end
      n_total++;
      if (RD_VALID !== (m_rv && RSTn)) $display("FAIL mon_rd_valid got %b want %b t=%0t", RD_VALID, (m_rv && RSTn), $time);
      else n_pass++;
      n_total++;
      if (RD_DATA !== exp_rd) $display("FAIL mon_rd_data got %h want %h t=%0t", RD_DATA, exp_rd, $time);
      else n_pass++;

      if (RD_VALID === 1'b1) obs.push_back(RD_DATA);

      if (!RSTn) begin
        mq.delete();
        m_rv = 1'b0; m_word = '0; m_hold = '0; m_wp = 0; m_rp = 0;
      end else begin
        if (m_rv) m_hold = m_word;
        m_rv = ra;
        if (ra) begin m_word = mq.pop_front(); m_rp = (m_rp + 1) % DEPTH; end
        if (wa) begin mq.push_back(WR_DATA); m_wp = (m_wp + 1) % DEPTH; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; WR_VALID = 1'b1; WR_DATA = 32'h55; RD_REQ = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if (RAM_WE !== 1'b0) $display("FAIL reset_we got %b want 0", RAM_WE);
      else n_pass++;
      if (i == 0) tick();
    end
    n_total++;
    if ({EMPTY, COUNT, RD_VALID, RD_DATA} !== {1'b1, 5'd0, 1'b0, 32'h0})
      $display("FAIL reset_state got e=%b c=%0d v=%b d=%h want e=1 c=0 v=0 d=0", EMPTY, COUNT, RD_VALID, RD_DATA);
    else n_pass++;
    tick();
    RSTn = 1'b1; WR_VALID = 1'b0;
    #1;
    n_total++;
    if (WR_READY !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", WR_READY);
    else n_pass++;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      WR_VALID = 1'b1; WR_DATA = 32'hA0 + 32'(i);
      tick();
    end
    WR_VALID = 1'b0;
    n_total++;
    if (RD_VALID !== 1'b0 || COUNT !== 5'd3) $display("FAIL basic_pre got v=%b c=%0d want v=0 c=3", RD_VALID, COUNT);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      RD_REQ = 1'b1;
      tick();
      n_total++;
      if (RD_VALID !== 1'b1 || RD_DATA !== 32'hA0 + 32'(i))
        $display("FAIL basic_read%0d got v=%b d=%h want v=1 d=%h", i, RD_VALID, RD_DATA, 32'hA0 + 32'(i));
      else n_pass++;
    end
    RD_REQ = 1'b0;
    tick();
    n_total++;
    if ({RD_VALID, COUNT, EMPTY, RD_DATA} !== {1'b0, 5'd0, 1'b1, 32'hA2})
      $display("FAIL basic_post got v=%b c=%0d e=%b d=%h want v=0 c=0 e=1 d=a2", RD_VALID, COUNT, EMPTY, RD_DATA);
    else n_pass++;
  endtask

  task automatic test_fill();
    logic [31:0] vals [16];
    for (int i = 0; i < 16; i++) begin
      vals[i] = $urandom & 32'h7FFF_FFFF;
      WR_VALID = 1'b1; WR_DATA = vals[i];
      tick();
      n_total++;
      if (ALMOST_FULL !== (i + 1 >= 12)) $display("FAIL fill_afull%0d got %b want %b", i, ALMOST_FULL, (i + 1 >= 12));
      else n_pass++;
    end
    WR_DATA = 32'hDEAD;
    #1;
    n_total++;
    if (WR_READY !== 1'b0 || FULL !== 1'b1) $display("FAIL fill_stall got rdy=%b full=%b want rdy=0 full=1", WR_READY, FULL);
    else n_pass++;
    tick();
    n_total++;
    if (COUNT !== 5'd16) $display("FAIL fill_count got %0d want 16", COUNT);
    else n_pass++;
    WR_VALID = 1'b0;
    obs.delete();
    RD_REQ = 1'b1;
    repeat (16) tick();
    RD_REQ = 1'b0;
    repeat (2) tick();
    n_total++;
    if (obs.size() != 16) $display("FAIL fill_nread got %0d want 16", obs.size());
    else n_pass++;
    for (int i = 0; i < 16 && i < obs.size(); i++) begin
      n_total++;
      if (obs[i] !== vals[i]) $display("FAIL fill_data%0d got %h want %h", i, obs[i], vals[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [$];
    obs.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) begin
        WR_VALID = 1'b1; WR_DATA = 32'hC000_0000 | 32'(r * 100 + i);
        exp.push_back(WR_DATA);
        tick();
      end
      WR_VALID = 1'b0; RD_REQ = 1'b1;
      repeat (10) tick();
      RD_REQ = 1'b0;
      tick();
    end
    tick();
    n_total++;
    if (obs != exp) $display("FAIL wrap_order got n=%0d want n=%0d", obs.size(), exp.size());
    else n_pass++;
    n_total++;
    if (COUNT !== 5'd0) $display("FAIL wrap_count got %0d want 0", COUNT);
    else n_pass++;
  endtask

  task automatic test_simul();
    for (int i = 0; i < 4; i++) begin
      WR_VALID = 1'b1; WR_DATA = 32'h5100 + 32'(i);
      tick();
    end
    WR_DATA = 32'h5104; RD_REQ = 1'b1;
    #1;
    n_total++;
    if ({RAM_RE, RAM_WE, WR_READY} !== 3'b100) $display("FAIL simul_arb got re/we/rdy=%b want 100", {RAM_RE, RAM_WE, WR_READY});
    else n_pass++;
    tick();
    n_total++;
    if (COUNT !== 5'd3) $display("FAIL simul_count3 got %0d want 3", COUNT);
    else n_pass++;
    RD_REQ = 1'b0;
    tick();
    n_total++;
    if (COUNT !== 5'd4) $display("FAIL simul_count4 got %0d want 4", COUNT);
    else n_pass++;
    WR_VALID = 1'b0; RD_REQ = 1'b1;
    repeat (4) tick();
    RD_REQ = 1'b0;
    tick();
  endtask

  task automatic test_empty_reset();
    RD_REQ = 1'b1;
    #1;
    n_total++;
    if (RAM_EN !== 1'b0) $display("FAIL empty_ram_en got %b want 0", RAM_EN);
    else n_pass++;
    tick();
    n_total++;
    if (RD_VALID !== 1'b0) $display("FAIL empty_rd_valid got %b want 0", RD_VALID);
    else n_pass++;
    RD_REQ = 1'b0; WR_VALID = 1'b1; WR_DATA = 32'h7777;
    tick();
    WR_VALID = 1'b0; RD_REQ = 1'b1;
    tick();
    RD_REQ = 1'b0; RSTn = 1'b0;
    #1;
    n_total++;
    if (RD_VALID !== 1'b0) $display("FAIL rst_rd_valid got %b want 0", RD_VALID);
    else n_pass++;
    tick();
    n_total++;
    if (COUNT !== 5'd0 || RD_VALID !== 1'b0) $display("FAIL rst_state got c=%0d v=%b want c=0 v=0", COUNT, RD_VALID);
    else n_pass++;
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int wbias;
      wbias    = (i % 200 < 100) ? 4 : 1;
      WR_VALID = ($urandom_range(0, 4) < wbias);
      WR_DATA  = $urandom;
      RD_REQ   = ($urandom_range(0, 4) >= wbias);
      RSTn     = ($urandom_range(0, 149) != 0);
      tick();
    end
    RSTn = 1'b1; WR_VALID = 1'b0; RD_REQ = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_simul();
    test_empty_reset();
    test_random();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
